dsm_decimator: RTL

- Decoding end of the MASH 1-1-1 delta-sigma modulator link: consumes the modulator's 5-bit two's-complement output stream and reconstructs the 24-bit fractional control word.
- Integrates the stream over a 2^WIN_LOG2-sample window and scales the result to 24 bits.
- Serves as an on-chip fractional-word monitor and as the self-check reference for DSM loopback verification.
- Runs on the same clock as the modulator.

---
 rtl/dsm_decimator.sv | 128 ++++++++++++
 1 files changed

// File: rtl/dsm_decimator.sv
// dsm_decimator: reconstructs the fractional control word from a MASH 1-1-1
// delta-sigma output stream by integrating it over a 2^WIN_LOG2-sample window.
//
// Handshake: Start is a request that is accepted only in IDLE (Busy=0); while
// Busy=1 it is ignored and not queued. Done is a one-cycle valid pulse, and
// Frac_Est/Sum_Out carry the result in that same cycle and hold it afterwards.
module dsm_decimator #(
    parameter int WIN_LOG2   = 12,
    parameter int SETTLE_CYC = 8
) (
    input  logic                       Clk,
    input  logic                       reset,
    input  logic [4:0]                 In_Data,
    input  logic                       Start,
    input  logic                       Cont,
    output logic [23:0]                Frac_Est,
    output logic signed [WIN_LOG2+3:0] Sum_Out,
    output logic                       Done,
    output logic                       Busy,
    output logic                       Range_Err,
    output logic [1:0]                 State_Dbg
);

    localparam int SW = WIN_LOG2 + 4;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SETTLE = 2'd1,
        S_ACCUM  = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    state_t                state;
    logic signed [SW-1:0]  acc;
    logic [WIN_LOG2-1:0]   samp_cnt;
    logic [7:0]            settle_cnt;

    logic signed [SW-1:0]  sample_ext;
    logic signed [SW-1:0]  acc_sum;
    logic                  sample_bad;
    logic [WIN_LOG2-1:0]   clamped;
    logic [23:0]           frac_next;

    assign State_Dbg  = state;
    assign sample_ext = {{(SW-5){In_Data[4]}}, In_Data};
    assign acc_sum    = acc + sample_ext;
    // Legal modulator outputs are -3..+4; anything else marks a broken link.
    assign sample_bad = (!In_Data[4] && (In_Data > 5'd4)) ||
                        ( In_Data[4] && (In_Data < 5'b11101));

    // Clamp the completed window sum into [0, 2^WIN_LOG2-1] before scaling.
    always_comb begin
        clamped = acc_sum[WIN_LOG2-1:0];
        if (acc_sum[SW-1]) begin
            clamped = '0;
        end else if (acc_sum[SW-2:WIN_LOG2] != '0) begin
            clamped = '1;
        end
    end

    assign frac_next = 24'(clamped) << (24 - WIN_LOG2);

    // Measurement FSM with registered Done/Busy/result outputs.
    always_ff @(posedge Clk) begin
        if (!reset) begin
            state      <= S_IDLE;
            acc        <= '0;
            samp_cnt   <= '0;
            settle_cnt <= '0;
            Frac_Est   <= '0;
            Sum_Out    <= '0;
            Done       <= 1'b0;
            Busy       <= 1'b0;
            Range_Err  <= 1'b0;
        end else begin
            Done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (Start) begin
                        acc        <= '0;
                        samp_cnt   <= '0;
                        settle_cnt <= '0;
                        Range_Err  <= 1'b0;
                        Busy       <= 1'b1;
                        state      <= (SETTLE_CYC == 0) ? S_ACCUM : S_SETTLE;
                    end
                end
                S_SETTLE: begin
                    // Modulator pipeline is still flushing; samples are ignored.
                    if (settle_cnt == 8'(SETTLE_CYC - 1)) begin
                        state <= S_ACCUM;
                    end else begin
                        settle_cnt <= settle_cnt + 8'd1;
                    end
                end
                S_ACCUM: begin
                    acc      <= acc_sum;
                    samp_cnt <= samp_cnt + 1'b1;
                    if (sample_bad) begin
                        Range_Err <= 1'b1;
                    end
                    if (&samp_cnt) begin
                        Sum_Out  <= acc_sum;
                        Frac_Est <= frac_next;
                        Done     <= 1'b1;
                        state    <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (Cont) begin
                        // This cycle's sample opens the next window.
                        acc      <= sample_ext;
                        samp_cnt <= WIN_LOG2'(1);
                        if (sample_bad) begin
                            Range_Err <= 1'b1;
                        end
                        state    <= S_ACCUM;
                    end else begin
                        Busy  <= 1'b0;
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
